// File: rtl/mining_chunk_bram_if.sv
// Mining chunk-memory port bundle.
// master: mining controller (drives strobes, address, field position, data).
// slave : chunk memory (returns line data, write-done pulse, error, write count).
interface mining_chunk_bram_if;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned AWID_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LINE_W = 512;
   localparam int unsigned CNT_W  = 16;

   logic              cs_n;
   logic              wr_n;
   logic              rd_n;
   logic [ADDR_W-1:0] addr;
   logic [AWID_W-1:0] addr_width;
   logic [DATA_W-1:0] bram_data_in;
   logic [LINE_W-1:0] bram_data_out;
   logic              wr_done;
   logic              err;
   logic [CNT_W-1:0]  wr_count;

   modport master (
      output cs_n, wr_n, rd_n, addr, addr_width, bram_data_in,
      input  bram_data_out, wr_done, err, wr_count
   );

   modport slave (
      input  cs_n, wr_n, rd_n, addr, addr_width, bram_data_in,
      output bram_data_out, wr_done, err, wr_count
   );
endinterface

// File: rtl/mining_chunk_bram.sv
// Chunk storage for the mining datapath: DEPTH lines of 512 bits.
// Ports: clock, reset (async, active-high), bus (slave modport):
//   cs_n/wr_n/rd_n active-low level strobes, addr line address,
//   addr_width MSB index of the 32-bit write field, bram_data_in write data,
//   bram_data_out registered read line, wr_done commit pulse,
//   err sticky error, wr_count committed-write counter.
module mining_chunk_bram #(
   parameter int unsigned DEPTH = 16
) (
   input  logic              clock,
   input  logic              reset,
   mining_chunk_bram_if.slave bus
);
   localparam int unsigned LINE_W = 512;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned AWID_W = 9;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AWID_W-1:0] MIN_AW = AWID_W'(DATA_W - 1);

   logic [LINE_W-1:0] mem_q [DEPTH];
   logic [LINE_W-1:0] mem_d [DEPTH];

   // S1 stage: captured write and the line it will merge into
   logic              s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0]  s1_idx_q,   s1_idx_d;
   logic [AWID_W-1:0] s1_aw_q,    s1_aw_d;
   logic [DATA_W-1:0] s1_data_q,  s1_data_d;
   logic [LINE_W-1:0] s1_line_q,  s1_line_d;
   // S2 stage: a commit happened on the previous edge
   logic              s2_valid_q, s2_valid_d;

   logic [LINE_W-1:0] dout_q,  dout_d;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              wr_acc_c, rd_acc_c, addr_ok_c, aw_ok_c;
   logic [IDX_W-1:0]  idx_c;
   logic [AWID_W-1:0] shift_c;
   logic [LINE_W-1:0] mask_c, merged_c, cur_line_c;

   // Field merge of the write held in S1; committed to memory this edge
   always_comb begin
      shift_c  = s1_aw_q - MIN_AW;
      mask_c   = LINE_W'({DATA_W{1'b1}}) << shift_c;
      merged_c = (s1_line_q & ~mask_c) | (LINE_W'(s1_data_q) << shift_c);
   end

   // Current view of the addressed line, forwarding the commit in flight
   always_comb begin
      wr_acc_c  = !bus.cs_n && !bus.wr_n;
      rd_acc_c  = !bus.cs_n && !bus.rd_n;
      addr_ok_c = bus.addr < ADDR_W'(DEPTH);
      aw_ok_c   = bus.addr_width >= MIN_AW;
      idx_c     = IDX_W'(bus.addr);
      cur_line_c = '0;
      if (addr_ok_c) begin
         if (s1_valid_q && (s1_idx_q == idx_c)) cur_line_c = merged_c;
         else                                    cur_line_c = mem_q[idx_c];
      end
   end

   // Next-state logic for memory, pipeline and outputs
   always_comb begin
      mem_d      = mem_q;
      s1_valid_d = 1'b0;
      s1_idx_d   = s1_idx_q;
      s1_aw_d    = s1_aw_q;
      s1_data_d  = s1_data_q;
      s1_line_d  = s1_line_q;
      s2_valid_d = s1_valid_q;
      dout_d     = dout_q;
      err_d      = err_q;
      count_d    = count_q;

      if (s1_valid_q) begin
         mem_d[s1_idx_q] = merged_c;
         count_d         = count_q + CNT_W'(1);
      end

      if (wr_acc_c) begin
         if (addr_ok_c && aw_ok_c) begin
            s1_valid_d = 1'b1;
            s1_idx_d   = idx_c;
            s1_aw_d    = bus.addr_width;
            s1_data_d  = bus.bram_data_in;
            s1_line_d  = cur_line_c;
         end else begin
            err_d = 1'b1;
         end
      end

      if (rd_acc_c) begin
         dout_d = cur_line_c;
         if (!addr_ok_c) err_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         s1_aw_q    <= '0;
         s1_data_q  <= '0;
         s1_line_q  <= '0;
         s2_valid_q <= 1'b0;
         dout_q     <= '0;
         err_q      <= 1'b0;
         count_q    <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
         s1_valid_q <= s1_valid_d;
         s1_idx_q   <= s1_idx_d;
         s1_aw_q    <= s1_aw_d;
         s1_data_q  <= s1_data_d;
         s1_line_q  <= s1_line_d;
         s2_valid_q <= s2_valid_d;
         dout_q     <= dout_d;
         err_q      <= err_d;
         count_q    <= count_d;
      end
   end

   assign bus.bram_data_out = dout_q;
   assign bus.wr_done       = s2_valid_q;
   assign bus.err           = err_q;
   assign bus.wr_count      = count_q;
endmodule

// File: tb/tb_mining_chunk_bram.sv
// Directed bench for mining_chunk_bram: vector table plus multi-cycle sequences.
module tb_mining_chunk_bram;
   logic clock;
   logic reset;
   int   total;
   int   bad;

   mining_chunk_bram_if bus ();

   mining_chunk_bram #(.DEPTH(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic         cs_n;
      logic         wr_n;
      logic         rd_n;
      logic [15:0]  addr;
      logic [8:0]   aw;
      logic [31:0]  data;
      logic [511:0] exp_out;
      logic         exp_done;
      logic [15:0]  exp_count;
      logic         exp_err;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic cs_n, logic wr_n, logic rd_n, logic [15:0] addr,
                               logic [8:0] aw, logic [31:0] data, logic [511:0] eo,
                               logic ed, logic [15:0] ec, logic ee);
      vec_t v;
      v.cs_n = cs_n; v.wr_n = wr_n; v.rd_n = rd_n; v.addr = addr; v.aw = aw;
      v.data = data; v.exp_out = eo; v.exp_done = ed; v.exp_count = ec; v.exp_err = ee;
      return v;
   endfunction

   function automatic logic [511:0] fld(logic [31:0] d, int msb);
      logic [511:0] l;
      l = 512'(d);
      return l << (msb - 31);
   endfunction

   task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic cs_n, logic wr_n, logic rd_n, logic [15:0] addr,
                        logic [8:0] aw, logic [31:0] data);
      bus.cs_n = cs_n; bus.wr_n = wr_n; bus.rd_n = rd_n;
      bus.addr = addr; bus.addr_width = aw; bus.bram_data_in = data;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [511:0] l3, l0, l5, hold_line;
      logic [31:0]  nv;
      int           pulses;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 16'd0, 9'd0, 32'd0);
      step();
      step();
      reset = 1'b0;

      chk("reset_out",   512'(bus.bram_data_out), '0);
      chk("reset_count", 512'(bus.wr_count), '0);
      chk("reset_err",   512'(bus.err), '0);

      // Write sampled, then reset before its commit edge
      drive(1'b0, 1'b0, 1'b1, 16'd2, 9'd511, 32'h12345678);
      step();
      reset = 1'b1;
      #1;
      chk("rstmid_done",  512'(bus.wr_done), '0);
      chk("rstmid_count", 512'(bus.wr_count), '0);
      drive(1'b1, 1'b1, 1'b1, 16'd0, 9'd0, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("rstmid_done2",  512'(bus.wr_done), '0);
      chk("rstmid_count2", 512'(bus.wr_count), '0);
      drive(1'b0, 1'b1, 1'b0, 16'd2, 9'd0, 32'd0);
      step();
      chk("rstmid_line", bus.bram_data_out, '0);
      drive(1'b1, 1'b1, 1'b1, 16'd0, 9'd0, 32'd0);
      step();

      l3 = fld(32'hDEADBEEF, 511);
      l0 = fld(32'h11111111, 511) | fld(32'h22222222, 127);
      l5 = fld(32'hCAFEF00D, 31);
      vecs[0]  = mk(0, 0, 1, 16'd3,  9'd511, 32'hDEADBEEF, '0, 0, 16'd0, 0);
      vecs[1]  = mk(0, 1, 0, 16'd3,  9'd0,   32'h0,        l3, 1, 16'd1, 0);
      vecs[2]  = mk(0, 0, 1, 16'd0,  9'd511, 32'h11111111, l3, 0, 16'd1, 0);
      vecs[3]  = mk(0, 0, 1, 16'd0,  9'd127, 32'h22222222, l3, 1, 16'd2, 0);
      vecs[4]  = mk(0, 1, 0, 16'd0,  9'd0,   32'h0,        l0, 1, 16'd3, 0);
      vecs[5]  = mk(1, 1, 1, 16'd0,  9'd0,   32'h0,        l0, 0, 16'd3, 0);
      vecs[6]  = mk(0, 0, 0, 16'd5,  9'd31,  32'hCAFEF00D, '0, 0, 16'd3, 0);
      vecs[7]  = mk(0, 1, 0, 16'd5,  9'd0,   32'h0,        l5, 1, 16'd4, 0);
      vecs[8]  = mk(1, 0, 0, 16'd5,  9'd31,  32'hFFFFFFFF, l5, 0, 16'd4, 0);
      vecs[9]  = mk(0, 0, 1, 16'd6,  9'd20,  32'hAAAAAAAA, l5, 0, 16'd4, 1);
      vecs[10] = mk(0, 1, 0, 16'd16, 9'd0,   32'h0,        '0, 0, 16'd4, 1);
      vecs[11] = mk(0, 0, 1, 16'd20, 9'd511, 32'hBBBBBBBB, '0, 0, 16'd4, 1);
      vecs[12] = mk(1, 1, 1, 16'd0,  9'd0,   32'h0,        '0, 0, 16'd4, 1);

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].cs_n, vecs[i].wr_n, vecs[i].rd_n, vecs[i].addr, vecs[i].aw, vecs[i].data);
         step();
         chk($sformatf("v%0d_out", i),   bus.bram_data_out, vecs[i].exp_out);
         chk($sformatf("v%0d_done", i),  512'(bus.wr_done), 512'(vecs[i].exp_done));
         chk($sformatf("v%0d_count", i), 512'(bus.wr_count), 512'(vecs[i].exp_count));
         chk($sformatf("v%0d_err", i),   512'(bus.err), 512'(vecs[i].exp_err));
      end

      // Nonce increment: read field, write back value+1, read again next edge
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 1'b0, 16'd1, 9'd0, 32'd0);
         step();
         nv = bus.bram_data_out[127:96];
         chk($sformatf("nonce_rd%0d", i), 512'(nv), 512'(i));
         drive(1'b0, 1'b0, 1'b1, 16'd1, 9'd127, nv + 32'd1);
         step();
      end
      drive(1'b0, 1'b1, 1'b0, 16'd1, 9'd0, 32'd0);
      step();
      chk("nonce_final", bus.bram_data_out, fld(32'd5, 127));
      chk("nonce_count", 512'(bus.wr_count), 512'(16'd9));

      // Held write strobe for ten cycles with constant data
      pulses = 0;
      hold_line = fld(32'hA5A5A5A5, 255);
      drive(1'b0, 1'b0, 1'b1, 16'd7, 9'd255, 32'hA5A5A5A5);
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.wr_done === 1'b1) pulses++;
      end
      drive(1'b0, 1'b1, 1'b0, 16'd7, 9'd0, 32'd0);
      step();
      if (bus.wr_done === 1'b1) pulses++;
      chk("held_line", bus.bram_data_out, hold_line);
      drive(1'b1, 1'b1, 1'b1, 16'd0, 9'd0, 32'd0);
      step();
      if (bus.wr_done === 1'b1) pulses++;
      step();
      if (bus.wr_done === 1'b1) pulses++;
      chk("held_pulses", 512'(pulses), 512'(10));
      chk("held_count",  512'(bus.wr_count), 512'(16'd19));
      chk("err_sticky",  512'(bus.err), 512'(1'b1));

      // Asynchronous reset clears everything including sticky err
      #2;
      reset = 1'b1;
      #1;
      chk("rst2_err",   512'(bus.err), '0);
      chk("rst2_count", 512'(bus.wr_count), '0);
      chk("rst2_out",   bus.bram_data_out, '0);
      step();
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 16'd3, 9'd0, 32'd0);
      step();
      chk("rst2_line3", bus.bram_data_out, '0);
      drive(1'b1, 1'b1, 1'b1, 16'd0, 9'd0, 32'd0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mining_chunk_bram.md
# mining_chunk_bram

Responder side of the mining chunk-memory port. Holds the block-header/message chunks as 512-bit lines and serves the mining controller's active-low strobe protocol. Accepts 32-bit field writes at a selectable MSB bit position (message and nonce updates) and returns a full 512-bit line on reads for the SHA-256 core. Sits between the mining FSM and the hash core and is the single owner of chunk storage.

## Interface

- DEPTH, 16, number of 512-bit lines (addresses 0..DEPTH-1)
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low; qualified by cs_n
- rd_n  in  1  read strobe, active low; qualified by cs_n
- addr  in  16  line address
- addr_width  in  9  bit index of the MSB of the 32-bit write field within the line
- bram_data_in  in  32  write data
- bram_data_out  out  512  registered read data
- wr_done  out  1  one-cycle pulse per committed write
- err  out  1  sticky error flag: out-of-range address or illegal addr_width
- wr_count  out  16  committed-write counter, wraps 0xFFFF to 0

## Operation

- Strobes are level-sensitive. Each rising edge with cs_n=0 and wr_n=0 accepts one write, and each with cs_n=0 and rd_n=0 accepts one read. A master holding wr_n low writes every cycle; identical repeated writes are idempotent.
- **Write pipeline**, two stages:
  - S1 registers addr, addr_width, data and the current line value.
  - S2 merges `line[addr_width -: 32] = data` and commits the line to memory.
  - Bits outside the field are unchanged.
- **Forwarding:** if S1 loads a line that S2 is committing in the same edge, S1 takes S2's merged value. Back-to-back writes to the same line never lose data.
- **Illegal write:** addr_width < 31 or addr >= DEPTH.
  - The write is dropped: no commit, no wr_done, no count.
  - err is set.
- **Read:** bram_data_out loads the line at addr. It reflects every write accepted on earlier edges, with in-flight S1/S2 results forwarded. It does not reflect a write accepted on the same edge.
- **Out-of-range read:** addr >= DEPTH returns all zeros and sets err.
- **Simultaneous read and write** on the same edge: both are accepted. The read follows the rule above.
- **No read accepted:** bram_data_out holds its last value.
- **cs_n=1:** all strobes are ignored. The pipeline still drains any accepted write.
- **States:** IDLE, S1_VALID, S2_COMMIT, expressed as per-stage valid bits so that stages overlap.
- err clears only on reset.

## Timing

- **Reset (asynchronous):**
  - All memory lines = 0, bram_data_out = 0.
  - wr_done = 0, err = 0, wr_count = 0.
  - Both pipeline stages invalid.
  - Any in-flight write is discarded and never committed. Accepts resume on the first edge after reset deasserts.
- **Write latency:**
  - Write sampled at edge E0.
  - Memory line updated at edge E1.
  - wr_done high and wr_count incremented for the cycle following E1.
- **Read latency:** 1 cycle. A read sampled at E0 gives bram_data_out valid after E0.
- **Throughput:** one write and one read per cycle, sustained. No stall or backpressure.
- **Read after write:** a write at E0 followed by a read at E1 to the same line returns the merged value.
- **wr_count:** wraps from 0xFFFF to 0x0000 with no flag.

## Test plan

- **Reset mid-write:** write sampled at E0, reset asserted before E1. Required: line stays 0, no wr_done, wr_count=0, all outputs 0.
- **Field write then read:** write addr=3, addr_width=511, data=0xDEADBEEF, then read addr=3. Required: bram_data_out[511:480]=0xDEADBEEF and the rest 0, one cycle after the read edge.
- **Back-to-back same-line writes:** addr=0 with addr_width=511 data=0x11111111, then addr_width=127 data=0x22222222, then read. Required: both fields present, wr_count=2.
- **Nonce increment loop:** read line 1, then write bits[127-:32] = read value + 1, repeated 5 times from 0. Required: field reads 5, wr_count=5.
- **Illegal accesses:**
  - addr_width=20 write: dropped, err=1.
  - addr=DEPTH read: returns 0.
  - err stays 1 until reset.
- **Held strobe:** wr_n low for 10 cycles with constant data. Required: line value is stable, wr_count=10, and 10 wr_done pulses.
